// File: rtl/eth_hdr_parser_64.sv
// eth_hdr_parser_64: splits a raw 64-bit AXI-Stream Ethernet frame into a
// 14-byte header (dest MAC, src MAC, ethertype) and a payload stream that is
// re-aligned so that frame byte 14 lands in lane 0.
module eth_hdr_parser_64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] s_axis_tdata,
  input  logic [7:0]  s_axis_tkeep,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic        m_eth_hdr_valid,
  input  logic        m_eth_hdr_ready,
  output logic [47:0] m_eth_dest_mac,
  output logic [47:0] m_eth_src_mac,
  output logic [15:0] m_eth_type,
  output logic [63:0] m_eth_payload_axis_tdata,
  output logic [7:0]  m_eth_payload_axis_tkeep,
  output logic        m_eth_payload_axis_tvalid,
  input  logic        m_eth_payload_axis_tready,
  output logic        m_eth_payload_axis_tlast,
  output logic        m_eth_payload_axis_tuser,
  output logic        busy,
  output logic        error_header_early_termination
);

  typedef enum logic [1:0] {IDLE, HDR1, PAYLOAD, FLUSH} state_t;

  state_t      r_state, w_next;
  logic        r_rdy_en;
  logic        r_hdr_valid;
  logic [47:0] r_dest, r_src;
  logic [15:0] r_type;
  logic [15:0] r_prev;       // bytes 6-7 of the previous input word
  logic [3:0]  r_last_cnt;   // keep count of the last input word (for FLUSH)
  logic        r_last_user;
  logic [63:0] r_tdata;
  logic [7:0]  r_tkeep;
  logic        r_tvalid, r_tlast, r_tuser;
  logic        r_err;
  logic        w_s_tready, w_acc, w_out_free;
  logic [3:0]  w_cnt;

  function automatic logic [3:0] keep_cnt(input logic [7:0] k);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) n = n + {3'd0, k[i]};
    return n;
  endfunction

  function automatic logic [7:0] cnt_keep(input logic [3:0] c);
    logic [8:0] m;
    m = (9'd1 << c) - 9'd1;
    return m[7:0];
  endfunction

  assign w_cnt      = keep_cnt(s_axis_tkeep);
  assign w_out_free = !r_tvalid || m_eth_payload_axis_tready;
  assign w_acc      = s_axis_tvalid && w_s_tready;

  // ready is held low until the first clock after reset release
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_rdy_en <= 1'b0;
    else        r_rdy_en <= 1'b1;

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;

  // next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_acc && !s_axis_tlast) w_next = HDR1;
      HDR1:    if (w_acc) begin
                 if (!s_axis_tlast)       w_next = PAYLOAD;
                 else if (w_cnt < 4'd7)   w_next = IDLE;
                 else                     w_next = FLUSH;
               end
      PAYLOAD: if (w_acc && s_axis_tlast) w_next = (w_cnt <= 4'd6) ? IDLE : FLUSH;
      FLUSH:   if (w_out_free) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // state-dependent outputs: input ready and busy
  always_comb begin
    w_s_tready = 1'b0;
    busy       = (r_state != IDLE);
    case (r_state)
      IDLE, HDR1: w_s_tready = r_rdy_en && !r_hdr_valid;
      PAYLOAD:    w_s_tready = r_rdy_en && w_out_free;
      default:    w_s_tready = 1'b0;
    endcase
  end

  // header capture, payload re-alignment register and error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hdr_valid <= 1'b0;
      r_dest      <= '0;
      r_src       <= '0;
      r_type      <= '0;
      r_prev      <= '0;
      r_last_cnt  <= '0;
      r_last_user <= 1'b0;
      r_tdata     <= '0;
      r_tkeep     <= '0;
      r_tvalid    <= 1'b0;
      r_tlast     <= 1'b0;
      r_tuser     <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (r_hdr_valid && m_eth_hdr_ready) r_hdr_valid <= 1'b0;
      if (m_eth_payload_axis_tready)      r_tvalid    <= 1'b0;
      case (r_state)
        IDLE: if (w_acc) begin
          if (s_axis_tlast) r_err <= 1'b1;
          else begin
            r_dest <= {s_axis_tdata[7:0], s_axis_tdata[15:8], s_axis_tdata[23:16],
                       s_axis_tdata[31:24], s_axis_tdata[39:32], s_axis_tdata[47:40]};
            r_src[47:32] <= {s_axis_tdata[55:48], s_axis_tdata[63:56]};
          end
        end
        HDR1: if (w_acc) begin
          if (s_axis_tlast && (w_cnt < 4'd7)) r_err <= 1'b1;
          else begin
            r_src[31:0] <= {s_axis_tdata[7:0], s_axis_tdata[15:8],
                            s_axis_tdata[23:16], s_axis_tdata[31:24]};
            r_type      <= {s_axis_tdata[39:32], s_axis_tdata[47:40]};
            r_hdr_valid <= 1'b1;
            r_prev      <= s_axis_tdata[63:48];
            r_last_cnt  <= w_cnt;
            r_last_user <= s_axis_tuser;
          end
        end
        PAYLOAD: if (w_acc) begin
          r_tvalid    <= 1'b1;
          r_tdata     <= {s_axis_tdata[47:0], r_prev};
          r_prev      <= s_axis_tdata[63:48];
          r_last_cnt  <= w_cnt;
          r_last_user <= s_axis_tuser;
          if (s_axis_tlast && (w_cnt <= 4'd6)) begin
            r_tkeep <= cnt_keep(w_cnt + 4'd2);
            r_tlast <= 1'b1;
            r_tuser <= s_axis_tuser;
          end else begin
            // last word with 7-8 bytes leaves 1-2 bytes for a trailing FLUSH word
            r_tkeep <= 8'hFF;
            r_tlast <= 1'b0;
            r_tuser <= 1'b0;
          end
        end
        FLUSH: if (w_out_free) begin
          r_tvalid <= 1'b1;
          r_tdata  <= {48'd0, r_prev};
          r_tkeep  <= cnt_keep(r_last_cnt - 4'd6);
          r_tlast  <= 1'b1;
          r_tuser  <= r_last_user;
        end
        default: ;
      endcase
    end
  end

  assign s_axis_tready                  = w_s_tready;
  assign m_eth_hdr_valid                = r_hdr_valid;
  assign m_eth_dest_mac                 = r_dest;
  assign m_eth_src_mac                  = r_src;
  assign m_eth_type                     = r_type;
  assign m_eth_payload_axis_tdata       = r_tdata;
  assign m_eth_payload_axis_tkeep       = r_tkeep;
  assign m_eth_payload_axis_tvalid      = r_tvalid;
  assign m_eth_payload_axis_tlast       = r_tlast;
  assign m_eth_payload_axis_tuser       = r_tuser;
  assign error_header_early_termination = r_err;

endmodule

// File: tb/tb_eth_hdr_parser_64.sv
// Bench for eth_hdr_parser_64: frames are built as byte lists; the expected
// header and payload words are derived from the frame bytes by chunking.
module tb_eth_hdr_parser_64;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] s_tdata;
  logic [7:0]  s_tkeep;
  logic        s_tvalid, s_tready, s_tlast, s_tuser;
  logic        hdr_valid, hdr_ready;
  logic [47:0] dest_mac, src_mac;
  logic [15:0] eth_type;
  logic [63:0] p_tdata;
  logic [7:0]  p_tkeep;
  logic        p_tvalid, p_tready, p_tlast, p_tuser;
  logic        busy, err;

  always #5 clk = ~clk;

  eth_hdr_parser_64 dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_eth_hdr_valid(hdr_valid), .m_eth_hdr_ready(hdr_ready),
    .m_eth_dest_mac(dest_mac), .m_eth_src_mac(src_mac), .m_eth_type(eth_type),
    .m_eth_payload_axis_tdata(p_tdata), .m_eth_payload_axis_tkeep(p_tkeep),
    .m_eth_payload_axis_tvalid(p_tvalid), .m_eth_payload_axis_tready(p_tready),
    .m_eth_payload_axis_tlast(p_tlast), .m_eth_payload_axis_tuser(p_tuser),
    .busy(busy), .error_header_early_termination(err)
  );

  typedef struct packed {logic [63:0] d; logic [7:0] k; logic l; logic u;} pw_t;
  typedef struct packed {logic [47:0] dst; logic [47:0] src; logic [15:0] typ;} hd_t;

  pw_t act_pl[$], exp_pl[$];
  hd_t act_hd[$], exp_hd[$];
  logic [7:0] tx_q[$];
  logic       tx_user;
  int err_seen = 0, exp_err = 0, n_chk = 0, n_err = 0;
  int pl_mode = 0, hr_mode = 0;
  logic [7:0] hc [14] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55,
                          8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h08, 8'h00};

  // sink: drive readies on the falling edge, then log what the next rising edge transfers
  always @(negedge clk) begin
    case (pl_mode)
      0: p_tready = 1'b1;
      1: p_tready = ~p_tready;
      default: p_tready = ($urandom % 4) != 0;
    endcase
    case (hr_mode)
      0: hdr_ready = 1'b1;
      1: hdr_ready = 1'b0;
      default: hdr_ready = ($urandom % 3) == 0;
    endcase
    if (rst_n) begin
      if (p_tvalid && p_tready) act_pl.push_back('{d: p_tdata, k: p_tkeep, l: p_tlast, u: p_tuser});
      if (hdr_valid && hdr_ready) act_hd.push_back('{dst: dest_mac, src: src_mac, typ: eth_type});
      if (err) err_seen++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] kmask(input logic [7:0] k);
    logic [63:0] m;
    for (int b = 0; b < 8; b++) m[b*8 +: 8] = {8{k[b]}};
    return m;
  endfunction

  // kind 1: canonical header constants and payload bytes counting from 0
  task automatic make_frame(input int len, input int kind);
    tx_q.delete();
    for (int i = 0; i < len; i++)
      if (kind == 1) tx_q.push_back(i < 14 ? hc[i] : 8'(i - 14));
      else           tx_q.push_back(8'($urandom));
  endtask

  // reference: a frame needs >= 15 bytes; payload is bytes 14.. chunked by 8
  task automatic expect_frame();
    int len = tx_q.size();
    int n;
    hd_t h;
    pw_t p;
    if (len < 15) begin
      exp_err++;
      return;
    end
    h = '0;
    for (int i = 0; i < 6; i++)   h.dst = {h.dst[39:0], tx_q[i]};
    for (int i = 6; i < 12; i++)  h.src = {h.src[39:0], tx_q[i]};
    for (int i = 12; i < 14; i++) h.typ = {h.typ[7:0], tx_q[i]};
    exp_hd.push_back(h);
    n = len - 14;
    for (int w = 0; w * 8 < n; w++) begin
      p = '0;
      for (int b = 0; b < 8; b++)
        if (w * 8 + b < n) begin
          p.d[b*8 +: 8] = tx_q[14 + w*8 + b];
          p.k[b] = 1'b1;
        end
      p.l = ((w + 1) * 8 >= n);
      p.u = p.l ? tx_user : 1'b0;
      exp_pl.push_back(p);
    end
  endtask

  // drives tx_q word by word; limit > 0 sends only that many words without tlast
  task automatic send_frame(input int limit);
    int len = tx_q.size();
    int nw = (len + 7) / 8;
    int to;
    for (int w = 0; w < nw; w++) begin
      if (limit > 0 && w >= limit) break;
      s_tdata = '0;
      s_tkeep = '0;
      for (int b = 0; b < 8; b++)
        if (w * 8 + b < len) begin
          s_tdata[b*8 +: 8] = tx_q[w*8 + b];
          s_tkeep[b] = 1'b1;
        end
      s_tlast  = (w == nw - 1);
      s_tuser  = s_tlast ? tx_user : 1'($urandom);
      s_tvalid = 1'b1;
      to = 0;
      #1;
      while (!s_tready && to < 500) begin
        @(negedge clk); #1;
        to++;
      end
      chk("src_wait_timeout", 64'(to >= 500), 64'd0);
      @(negedge clk);
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
  endtask

  task automatic drain();
    int to = 0;
    pl_mode = 0;
    hr_mode = 0;
    while ((act_pl.size() < exp_pl.size() || act_hd.size() < exp_hd.size() ||
            err_seen < exp_err) && to < 3000) begin
      @(negedge clk);
      to++;
    end
    repeat (6) @(negedge clk);
    chk("drain_timeout", 64'(to >= 3000), 64'd0);
  endtask

  task automatic compare();
    int nh = act_hd.size() < exp_hd.size() ? act_hd.size() : exp_hd.size();
    int np = act_pl.size() < exp_pl.size() ? act_pl.size() : exp_pl.size();
    chk("hdr_count", 64'(act_hd.size()), 64'(exp_hd.size()));
    chk("pl_count",  64'(act_pl.size()), 64'(exp_pl.size()));
    chk("err_count", 64'(err_seen), 64'(exp_err));
    for (int i = 0; i < nh; i++) begin
      chk("hdr_dst", 64'(act_hd[i].dst), 64'(exp_hd[i].dst));
      chk("hdr_src", 64'(act_hd[i].src), 64'(exp_hd[i].src));
      chk("hdr_typ", 64'(act_hd[i].typ), 64'(exp_hd[i].typ));
    end
    for (int i = 0; i < np; i++) begin
      chk("pl_keep", 64'(act_pl[i].k), 64'(exp_pl[i].k));
      chk("pl_data", act_pl[i].d & kmask(exp_pl[i].k), exp_pl[i].d);
      chk("pl_last", 64'(act_pl[i].l), 64'(exp_pl[i].l));
      chk("pl_user", 64'(act_pl[i].u), 64'(exp_pl[i].u));
    end
    act_hd.delete(); exp_hd.delete();
    act_pl.delete(); exp_pl.delete();
  endtask

  initial begin
    int stalls;
    s_tdata = '0; s_tkeep = '0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
    tx_user = 1'b0;
    repeat (3) @(negedge clk);
    // reset state
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    chk("rst_hdr_valid", 64'(hdr_valid), 64'd0);
    chk("rst_p_tvalid", 64'(p_tvalid), 64'd0);
    chk("rst_p_tlast", 64'(p_tlast), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_dest", 64'(dest_mac), 64'd0);
    chk("rst_tdata", p_tdata, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_s_tready", 64'(s_tready), 64'd1);

    // full-size 64-byte frame
    make_frame(64, 1); tx_user = 1'b0; expect_frame(); send_frame(0); drain();
    chk("full_dst", 64'(act_hd[0].dst), 64'h001122334455);
    chk("full_src", 64'(act_hd[0].src), 64'hAABBCCDDEEFF);
    chk("full_typ", 64'(act_hd[0].typ), 64'h0800);
    chk("full_nwords", 64'(act_pl.size()), 64'd7);
    chk("full_w0", act_pl[0].d, 64'h0706050403020100);
    chk("full_last_keep", 64'(act_pl[6].k), 64'h03);
    chk("full_last_tlast", 64'(act_pl[6].l), 64'd1);
    compare();

    // minimum payload: 15 bytes
    make_frame(15, 0); expect_frame(); send_frame(0); drain();
    chk("min_keep", 64'(act_pl[0].k), 64'h01);
    chk("min_byte14", 64'(act_pl[0].d[7:0]), 64'(tx_q[14]));
    chk("min_tlast", 64'(act_pl[0].l), 64'd1);
    compare();

    // early termination: 12 bytes
    make_frame(12, 0); expect_frame(); send_frame(0); #1;
    chk("early_err_pulse", 64'(err), 64'd1);
    chk("early_busy", 64'(busy), 64'd0);
    chk("early_hdr_valid", 64'(hdr_valid), 64'd0);
    chk("early_s_tready", 64'(s_tready), 64'd1);
    @(negedge clk); #1;
    chk("early_err_width", 64'(err), 64'd0);
    drain(); compare();

    // tuser on a 30-byte frame
    make_frame(30, 0); tx_user = 1'b1; expect_frame(); send_frame(0); drain();
    chk("tuser_keep", 64'(act_pl[1].k), 64'hFF);
    chk("tuser_tlast", 64'(act_pl[1].l), 64'd1);
    chk("tuser_user", 64'(act_pl[1].u), 64'd1);
    compare();
    tx_user = 1'b0;

    // reset in the middle of the payload
    make_frame(64, 1); send_frame(3);
    @(negedge clk); #2;
    rst_n = 1'b0; #1;
    chk("mid_rst_hdr_valid", 64'(hdr_valid), 64'd0);
    chk("mid_rst_p_tvalid", 64'(p_tvalid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_err", 64'(err), 64'd0);
    chk("mid_rst_s_tready", 64'(s_tready), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    act_hd.delete(); act_pl.delete();
    make_frame(64, 1); expect_frame(); send_frame(0); drain();
    chk("after_rst_dst", 64'(act_hd[0].dst), 64'h001122334455);
    compare();

    // backpressure: header held, payload ready toggling, back-to-back frame
    pl_mode = 1; hr_mode = 1;
    make_frame(64, 0); expect_frame(); send_frame(0);
    make_frame(40, 0); expect_frame();
    stalls = 0;
    fork
      send_frame(0);
      begin
        repeat (20) begin
          @(negedge clk); #1;
          if (s_tready) stalls++;
        end
        chk("bp_word0_stall", 64'(stalls), 64'd0);
        chk("bp_hdr_pending", 64'(hdr_valid), 64'd1);
        hr_mode = 0;
      end
    join
    drain(); compare();

    // randomized frames with random backpressure on both outputs
    pl_mode = 2; hr_mode = 2;
    for (int f = 0; f < 30; f++) begin
      make_frame(($urandom % 5 == 0) ? $urandom_range(1, 14) : $urandom_range(15, 120), 0);
      tx_user = 1'($urandom);
      expect_frame();
      send_frame(0);
    end
    drain(); compare();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/eth_hdr_parser_64.md
Name: eth_hdr_parser_64

Overview:
- Receive-side counterpart of the block that consumes the s_eth header/payload interface.
- Takes a raw 64-bit AXI-Stream Ethernet frame (from MAC RX) and splits it into an eth header (dest MAC, src MAC, type) plus a re-aligned 64-bit payload stream.
- Output signals mirror the s_eth bundle with m_ prefix, so the tx path's input can be driven directly in loopback benches.

Parameters:
- None. Data width fixed at 64 bits, keep at 8 bits.

Ports:
- clk  input  1  single clock
- rst_n  input  1  asynchronous, active-low reset
- s_axis_tdata  input  64  raw frame data, byte 0 = [7:0]
- s_axis_tkeep  input  8  byte enables, contiguous from bit 0
- s_axis_tvalid  input  1
- s_axis_tready  output  1
- s_axis_tlast  input  1
- s_axis_tuser  input  1  bad-frame flag
- m_eth_hdr_valid  output  1
- m_eth_hdr_ready  input  1
- m_eth_dest_mac  output  48  byte0 in [47:40]
- m_eth_src_mac  output  48  byte6 in [47:40]
- m_eth_type  output  16  {byte12, byte13}
- m_eth_payload_axis_tdata  output  64
- m_eth_payload_axis_tkeep  output  8
- m_eth_payload_axis_tvalid  output  1
- m_eth_payload_axis_tready  input  1
- m_eth_payload_axis_tlast  output  1
- m_eth_payload_axis_tuser  output  1
- busy  output  1  high when state != IDLE
- error_header_early_termination  output  1  one-cycle pulse

Behaviour:
- Reset (async assert, sync deassert use): state IDLE; all m_* valids, tlast, tuser, busy and error are 0; data/mac/type are 0; s_axis_tready is 0 during reset and 1 on the first cycle after release.
- Header occupies bytes 0-13. Payload starts at byte 14 = word1 byte 6, so each output word is {cur[47:0], prev[63:48]}. prev holds bytes 6-7 of the previous input word.
- States: IDLE, HDR1, PAYLOAD, FLUSH.
- IDLE: s_tready = !m_eth_hdr_valid.
  - Accepting word0 captures dest_mac and src_mac[47:32]; go to HDR1.
  - If word0 has tlast: pulse error, stay IDLE.
- HDR1: s_tready = !m_eth_hdr_valid.
  - Accepting word1 loads src_mac[31:0], type and prev, and sets m_eth_hdr_valid in the next cycle.
  - If tlast and keep count < 7: no header, error pulse, go to IDLE.
  - If tlast and count is 7 or 8: header valid; go to FLUSH emitting one word with keep count-6.
  - Otherwise go to PAYLOAD.
- PAYLOAD: s_tready = !m_payload_tvalid || m_payload_tready. Each accepted word c (keep count):
  - Not last: output full word, keep 0xFF.
  - Last with c <= 6: output keep count c+2, tlast=1, go to IDLE.
  - Last with c in 7..8: output full word, tlast=0, go to FLUSH.
- FLUSH: s_tready = 0. Output prev bytes as a word with keep count c-6 in the low lanes, tlast=1. Go to IDLE when accepted.
- Header handshake:
  - m_eth_hdr_valid is held until m_eth_hdr_ready.
  - Fields are stable while valid.
  - Payload of the current frame streams independently of the header handshake.
  - The next frame's word0 is not accepted until the previous header is consumed.
- Payload output is a single register stage, and full throughput is required: one word per cycle when ready is held high.
- tuser: the OR of s_tuser over the last input word is presented on the output word carrying tlast. Non-last output words have tuser=0.
- tkeep on non-last input words is required to be 0xFF; violations are unchecked and the result is undefined.
- Simultaneous events: in PAYLOAD, output consumption and input acceptance in the same cycle are allowed.
- Reset mid-frame: all state is cleared immediately; any partial output is discarded.

Test Plan:
- Full-size frame: 64-byte frame (8 words, all keep 0xFF), dest 0x001122334455, src 0xAABBCCDDEEFF, type 0x0800, payload bytes 0x00..0x31.
  - Header fields match exactly.
  - 7 payload words; the first word's tdata is 0x0706050403020100; the last word has keep 0x03 and tlast=1.
- Minimum payload: 15-byte frame (word1 keep 0x7F, tlast) -> header valid; one payload word with keep 0x01, tdata[7:0] = byte 14, tlast=1.
- Early termination: 12-byte frame (word1 keep 0x0F, tlast) -> error pulses for exactly 1 cycle, no hdr_valid, busy=0 next cycle, s_tready=1.
- Backpressure: m_eth_hdr_ready low for 20 cycles, payload tready toggling 1010.
  - Payload completes with no loss or duplication.
  - A back-to-back second frame's word0 is stalled (s_tready=0) until hdr_ready.
- tuser propagation: 30-byte frame with s_tuser=1 on the last word (keep 0x3F) -> final output word has keep 0xFF, tlast=1, tuser=1.
- Reset mid-frame: rst_n low mid-PAYLOAD -> all valids 0 immediately; a subsequent clean 64-byte frame is parsed correctly.
